lcd_write_arbiter: RTL and testbench
====================================

# lcd_write_arbiter

Shared write scheduler for the 4-bit HD44780-style LCD bus. It accepts byte or single-nibble write requests, each tagged command or data, from several requesters, such as the init/refresh sequencer and a text writer. It grants one request at a time with round-robin fairness. For each granted request it generates the nibble split, the EN pulses and the post-write settle delay. Requesters never drive en/rs/data directly; this block is the only driver of the LCD pins.

## Interface
- NUM_REQ, 2, number of requesters (2..4).
- EN_HIGH_CYCLES, 1, clk cycles EN is held high per nibble (>=1).
- NIBBLE_GAP_CYCLES, 1, EN-low cycles between high and low nibble (>=1).
- SHORT_WAIT_CYCLES, 1, settle cycles after an ordinary write (>=1).
- LONG_WAIT_CYCLES, 2, settle cycles after clear/home commands (>=1).

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester request; held with payload stable until gnt.
- req_rs  in  NUM_REQ  0 = command, 1 = data.
- req_nib  in  NUM_REQ  1 = nibble-only write (data[7:4] only).
- req_data  in  8*NUM_REQ  payload; requester i uses bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot, one-cycle pulse; payload latched.
- busy  out  1  high whenever the state is not IDLE.
- en  out  1  LCD enable.
- rs  out  1  LCD register select.
- data  out  4  LCD data nibble.

## Operation
- States: IDLE, HI_EN, HI_GAP, LO_EN, WAIT.
- Reset values: en=0, rs=0, data=0, gnt=0, busy=0, state=IDLE, counter=0, rr pointer=NUM_REQ-1, so requester 0 wins first.
- IDLE: if any req is high, the winner is the first requester with req high, searching from pointer+1 upward with wrap.
  - On that edge: latch rs, nib and byte; pulse gnt[winner]; set pointer=winner; go to HI_EN.
  - No req: stay in IDLE with outputs held.
- HI_EN: en=1, data=byte[7:4], rs=latched rs, for EN_HIGH_CYCLES cycles.
  - Then go to WAIT if nib=1, else to HI_GAP.
- HI_GAP: en=0, data and rs held, for NIBBLE_GAP_CYCLES cycles, then LO_EN.
- LO_EN: en=1, data=byte[3:0], for EN_HIGH_CYCLES cycles, then WAIT.
- WAIT: en=0, data and rs held.
  - Duration is LONG_WAIT_CYCLES if rs=0, nib=0 and byte is 0x01 or 0x02; otherwise SHORT_WAIT_CYCLES.
  - Then go to IDLE.
- data and rs change only on the edge that raises en. They are stable during every EN-high cycle and through the following EN-low cycle.
- A req that drops before it is granted is ignored. Requests that are not granted are never queued internally.
- Reset mid-operation: on the reset edge, en drops and the state returns to IDLE. The latched transfer is discarded with no further pulses, and no gnt is issued in the reset cycle.
- Requests arriving while busy wait; they are evaluated in the next IDLE cycle.

## Timing
- Grant latency: a req sampled high in IDLE gets gnt high in the next cycle, together with en=1 of HI_EN.
- Byte write, default parameters: busy is high for 4 cycles (HI_EN, HI_GAP, LO_EN, WAIT), followed by 1 IDLE cycle.
  - Back-to-back grants are therefore 5 cycles apart.
- Long-command byte write: busy for 5 cycles; grant spacing 6 cycles.
- Nibble-only write: busy for 2 cycles (HI_EN, WAIT); grant spacing 3 cycles.
- Wait counter width: $clog2 of the largest cycle parameter, plus 1. It loads on each state entry and counts down to 1.
- gnt is never high in two consecutive cycles. At most one gnt bit is high at any time.

## Structure
- Shared package lcd_pkg holds:
  - the state enum;
  - the long-command constants LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME=8'h02;
  - the nibble width constant.
- Sub-module lcd_rr_arbiter: combinational round-robin winner select. Inputs are req and pointer; outputs are a one-hot winner and its index. The FSM, counter and registers stay in the top level.

## Test plan
- req[0]=1, rs=1, data=0x41 -> gnt[0] pulses one cycle; en goes high with data=4, then high again with data=1; rs=1 throughout; busy high for exactly 4 cycles.
- req[1]=1, rs=0, data=0x01 -> en pulses with data 0 then 1; WAIT lasts 2 cycles; busy high for 5 cycles.
- req[0]=1, nib=1, rs=0, data=0x30 -> a single en pulse with data=3; busy high for 2 cycles; gnt[0] again 3 cycles later if req is held.
- req[0] and req[1] held high continuously with byte payloads -> gnt order 0,1,0,1 at 5-cycle spacing; never two gnt bits high together.
- Reset asserted during LO_EN -> the next cycle has en=0, busy=0, state IDLE, no further en pulses. With both reqs high after reset, gnt[0] comes first.
- req[1] pulsed for one cycle while busy, then dropped -> no gnt[1]; the bus stays idle after the current transfer.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the 4-bit LCD write scheduler: FSM states,
// commands that need the long settle time, and the bus nibble width.
package lcd_pkg;

   // Width of the LCD data bus in 4-bit mode.
   localparam int LCD_NIB_W = 4;

   // These two commands need the long settle time after they are written.
   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

   // Write sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HI_EN  = 3'd1,
      ST_HI_GAP = 3'd2,
      ST_LO_EN  = 3'd3,
      ST_WAIT   = 3'd4
   } lcd_state_e;

   // Full-byte clear/home commands need the long settle time.
   function automatic logic is_long_cmd(input logic       rs_val,
                                        input logic       nib_val,
                                        input logic [7:0] byte_val);
      logic hit;
      hit = (byte_val == LCD_CMD_CLEAR) || (byte_val == LCD_CMD_HOME);
      return (!rs_val) && (!nib_val) && hit;
   endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin winner select. The search starts at the
// requester after the pointer and wraps around, so the last winner has the
// lowest priority.
module lcd_rr_arbiter
   import lcd_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
)
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] win_oh_o,
   output logic [PTR_W-1:0]   win_idx_o,
   output logic               win_vld_o
);

   logic             found_s;
   logic [PTR_W-1:0] cand_idx_s;
   int               cand_s;

   // Pick the first active requester after the pointer, with wrap-around.
   always_comb begin
      found_s    = 1'b0;
      cand_s     = 0;
      cand_idx_s = '0;
      win_oh_o   = '0;
      win_idx_o  = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand_s     = (int'(ptr_i) + off) % NUM_REQ;
         cand_idx_s = cand_s[PTR_W-1:0];
         if (!found_s && req_i[cand_idx_s]) begin
            found_s              = 1'b1;
            win_idx_o            = cand_idx_s;
            win_oh_o[cand_idx_s] = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      win_vld_o = found_s;
   end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shared write scheduler for the 4-bit HD44780-style LCD bus. Grants one
// requester at a time (round robin), splits the byte into nibbles, generates
// the EN pulses and applies the post-write settle delay. This is the only
// driver of the LCD pins.
module lcd_write_arbiter
   import lcd_pkg::*;
#(
   parameter int NUM_REQ           = 2,
   parameter int EN_HIGH_CYCLES    = 1,
   parameter int NIBBLE_GAP_CYCLES = 1,
   parameter int SHORT_WAIT_CYCLES = 1,
   parameter int LONG_WAIT_CYCLES  = 2
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     req_rs,
   input  logic [NUM_REQ-1:0]     req_nib,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     gnt,
   output logic                   busy,
   output logic                   en,
   output logic                   rs,
   output logic [LCD_NIB_W-1:0]   data
);

   localparam int MAX_EN_GAP = (EN_HIGH_CYCLES > NIBBLE_GAP_CYCLES) ?
                               EN_HIGH_CYCLES : NIBBLE_GAP_CYCLES;
   localparam int MAX_WAIT   = (SHORT_WAIT_CYCLES > LONG_WAIT_CYCLES) ?
                               SHORT_WAIT_CYCLES : LONG_WAIT_CYCLES;
   localparam int MAX_CYC    = (MAX_EN_GAP > MAX_WAIT) ? MAX_EN_GAP : MAX_WAIT;
   localparam int CNT_W      = $clog2(MAX_CYC) + 1;
   localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_EN    = CNT_W'(EN_HIGH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(NIBBLE_GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(SHORT_WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(LONG_WAIT_CYCLES);
   localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);

   // Sequencer state and latched transfer.
   lcd_state_e                 state_q;
   logic [CNT_W-1:0]           cnt_q;
   logic [PTR_W-1:0]           ptr_q;
   logic [7:0]                 byte_q;
   logic                       nib_q;
   logic [NUM_REQ-1:0]         gnt_q;
   logic                       busy_q;
   logic                       en_q;
   logic                       rs_q;
   logic [LCD_NIB_W-1:0]       data_q;

   // Arbiter result and winner payload.
   logic [NUM_REQ-1:0]         win_oh_s;
   logic [PTR_W-1:0]           win_idx_s;
   logic                       win_vld_s;
   logic [7:0]                 win_byte_s;
   logic                       win_rs_s;
   logic                       win_nib_s;
   logic [CNT_W-1:0]           wait_len_s;
   logic [CNT_W-1:0]           cnt_dec_d;

   lcd_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .win_oh_o  (win_oh_s),
      .win_idx_o (win_idx_s),
      .win_vld_o (win_vld_s)
   );

   // Select the winning requester's payload and derive the settle length.
   always_comb begin
      win_byte_s = req_data[{win_idx_s, 3'b000} +: 8];
      win_rs_s   = req_rs[win_idx_s];
      win_nib_s  = req_nib[win_idx_s];
      wait_len_s = is_long_cmd(rs_q, nib_q, byte_q) ? CNT_LONG : CNT_SHORT;
      cnt_dec_d  = cnt_q - CNT_ONE;
   end

   // Write sequencer: grant, nibble EN pulses and settle delay; all pin
   // outputs are registered here. rs/data only change on edges raising en.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= PTR_RST;
         byte_q  <= 8'h00;
         nib_q   <= 1'b0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         en_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         gnt_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (win_vld_s) begin
                  gnt_q   <= win_oh_s;
                  ptr_q   <= win_idx_s;
                  byte_q  <= win_byte_s;
                  nib_q   <= win_nib_s;
                  rs_q    <= win_rs_s;
                  data_q  <= win_byte_s[7:4];
                  en_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= CNT_EN;
                  state_q <= ST_HI_EN;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_HI_EN: begin
               if (cnt_q == CNT_ONE) begin
                  en_q <= 1'b0;
                  if (nib_q) begin
                     cnt_q   <= wait_len_s;
                     state_q <= ST_WAIT;
                  end else begin
                     cnt_q   <= CNT_GAP;
                     state_q <= ST_HI_GAP;
                  end
               end else begin
                  cnt_q <= cnt_dec_d;
               end
            end
            ST_HI_GAP: begin
               if (cnt_q == CNT_ONE) begin
                  en_q    <= 1'b1;
                  data_q  <= byte_q[3:0];
                  cnt_q   <= CNT_EN;
                  state_q <= ST_LO_EN;
               end else begin
                  cnt_q <= cnt_dec_d;
               end
            end
            ST_LO_EN: begin
               if (cnt_q == CNT_ONE) begin
                  en_q    <= 1'b0;
                  cnt_q   <= wait_len_s;
                  state_q <= ST_WAIT;
               end else begin
                  cnt_q <= cnt_dec_d;
               end
            end
            ST_WAIT: begin
               if (cnt_q == CNT_ONE) begin
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_dec_d;
               end
            end
            default: begin
               en_q    <= 1'b0;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt  = gnt_q;
   assign busy = busy_q;
   assign en   = en_q;
   assign rs   = rs_q;
   assign data = data_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with default parameters.
module tb_lcd_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  req_rs;
   logic [1:0]  req_nib;
   logic [15:0] req_data;
   logic [1:0]  gnt;
   logic        busy;
   logic        en;
   logic        rs;
   logic [3:0]  data;

   int n_tests = 0;
   int n_fail  = 0;

   lcd_write_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_rs   (req_rs),
      .req_nib  (req_nib),
      .req_data (req_data),
      .gnt      (gnt),
      .busy     (busy),
      .en       (en),
      .rs       (rs),
      .data     (data)
   );

   // 10 time-unit clock.
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check all pin outputs at once.
   task automatic chk_pins(input string tag, input logic [1:0] e_gnt, input logic e_busy,
                           input logic e_en, input logic e_rs, input logic [3:0] e_data);
      chk({tag, ".gnt"},  32'(gnt),  32'(e_gnt));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      chk({tag, ".en"},   32'(en),   32'(e_en));
      chk({tag, ".rs"},   32'(rs),   32'(e_rs));
      chk({tag, ".data"}, 32'(data), 32'(e_data));
   endtask

   initial begin
      reset    = 1'b1;
      req      = 2'b00;
      req_rs   = 2'b00;
      req_nib  = 2'b00;
      req_data = 16'h0000;
      tick();
      tick();
      chk_pins("rst", 2'b00, 1'b0, 1'b0, 1'b0, 4'h0);
      reset = 1'b0;
      tick();
      chk_pins("idle", 2'b00, 1'b0, 1'b0, 1'b0, 4'h0);

      // Data byte 0x41 from requester 0.
      req = 2'b01; req_rs = 2'b01; req_nib = 2'b00; req_data = 16'h0041;
      tick();
      chk_pins("b41.hien", 2'b01, 1'b1, 1'b1, 1'b1, 4'h4);
      req = 2'b00;
      tick();
      chk_pins("b41.gap", 2'b00, 1'b1, 1'b0, 1'b1, 4'h4);
      tick();
      chk_pins("b41.loen", 2'b00, 1'b1, 1'b1, 1'b1, 4'h1);
      tick();
      chk_pins("b41.wait", 2'b00, 1'b1, 1'b0, 1'b1, 4'h1);
      tick();
      chk_pins("b41.idle", 2'b00, 1'b0, 1'b0, 1'b1, 4'h1);

      // Nibble-only command 0x30 from requester 0, held for a repeat grant.
      req = 2'b01; req_rs = 2'b00; req_nib = 2'b01; req_data = 16'h0030;
      tick();
      chk_pins("n30.hien", 2'b01, 1'b1, 1'b1, 1'b0, 4'h3);
      tick();
      chk_pins("n30.wait", 2'b00, 1'b1, 1'b0, 1'b0, 4'h3);
      tick();
      chk_pins("n30.idle", 2'b00, 1'b0, 1'b0, 1'b0, 4'h3);
      tick();
      chk_pins("n30.regnt", 2'b01, 1'b1, 1'b1, 1'b0, 4'h3);
      req = 2'b00;
      tick();
      tick();
      chk_pins("n30.end", 2'b00, 1'b0, 1'b0, 1'b0, 4'h3);

      // Clear command 0x01 from requester 1: long settle.
      req = 2'b10; req_rs = 2'b00; req_nib = 2'b00; req_data = 16'h0100;
      tick();
      chk_pins("c01.hien", 2'b10, 1'b1, 1'b1, 1'b0, 4'h0);
      req = 2'b00;
      tick();
      chk_pins("c01.gap", 2'b00, 1'b1, 1'b0, 1'b0, 4'h0);
      tick();
      chk_pins("c01.loen", 2'b00, 1'b1, 1'b1, 1'b0, 4'h1);
      tick();
      chk_pins("c01.wait1", 2'b00, 1'b1, 1'b0, 1'b0, 4'h1);
      tick();
      chk_pins("c01.wait2", 2'b00, 1'b1, 1'b0, 1'b0, 4'h1);
      tick();
      chk_pins("c01.idle", 2'b00, 1'b0, 1'b0, 1'b0, 4'h1);

      // Both held with data bytes: alternating grants 5 cycles apart.
      req = 2'b11; req_rs = 2'b11; req_nib = 2'b00; req_data = 16'hAA55;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("rr%0d.gnt", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("rr%0d.data", k), 32'(data), (k % 2 == 0) ? 32'h5 : 32'hA);
         for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("rr%0d.gap%0d", k, j), 32'(gnt), 32'h0);
         end
      end
      req = 2'b00;

      // Reset during LO_EN.
      req = 2'b01; req_rs = 2'b01; req_data = 16'h0041;
      tick();
      chk_pins("rmid.hien", 2'b01, 1'b1, 1'b1, 1'b1, 4'h4);
      req = 2'b00;
      tick();
      tick();
      chk_pins("rmid.loen", 2'b00, 1'b1, 1'b1, 1'b1, 4'h1);
      reset = 1'b1;
      req = 2'b11;
      tick();
      chk_pins("rmid.rst", 2'b00, 1'b0, 1'b0, 1'b0, 4'h0);
      reset = 1'b0;
      req = 2'b00;
      tick();
      chk_pins("rmid.quiet", 2'b00, 1'b0, 1'b0, 1'b0, 4'h0);
      req = 2'b11; req_rs = 2'b11; req_data = 16'hAA55;
      tick();
      chk_pins("rmid.first", 2'b01, 1'b1, 1'b1, 1'b1, 4'h5);
      req = 2'b00;
      for (int j = 0; j < 4; j++) tick();
      chk("rmid.done.busy", 32'(busy), 32'h0);

      // Short req[1] pulse while busy is ignored.
      req = 2'b01; req_rs = 2'b01; req_data = 16'h0041;
      tick();
      chk("drop.gnt0", 32'(gnt), 32'h1);
      req = 2'b10;
      tick();
      req = 2'b00;
      for (int j = 0; j < 4; j++) begin
         tick();
         chk($sformatf("drop.nogrant%0d", j), 32'(gnt), 32'h0);
      end
      chk_pins("drop.idle", 2'b00, 1'b0, 1'b0, 1'b1, 4'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
